output_matrix_fifo: RTL and testbench

//  Parametrised result-matrix output buffer, successor to the single-entry output register.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/fifo_ctrl.sv | 60 ++++++
 rtl/output_matrix_fifo.sv | 53 +++++
 tb/tb_output_matrix_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Matrix geometry shared by the ALU writeback, the output FIFO and the bench.
// elem_offset gives the bit position of element (r,c) inside a packed matrix.
package matrix_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAT_W  = ELEM_W * ROWS * COLS;

  function automatic int unsigned elem_offset(input int unsigned r, input int unsigned c);
    return (r * COLS + c) * ELEM_W;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for the matrix output FIFO.
// Any DEPTH >= 2 is supported; pointers wrap explicitly at DEPTH-1.
module fifo_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write_data,
  input  logic             read_ack,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             push,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             data_valid,
  output logic             overflow
);

  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop frees the slot a push on a full FIFO needs, so push depends on pop.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    if (!clear) begin
      pop  = read_ack && (count != '0);
      push = write_data && ((count != CNT_W'(DEPTH)) || pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (write_data && !push) overflow <= 1'b1;
    end
  end

  assign full       = (count == CNT_W'(DEPTH));
  assign data_valid = (count != '0);

endmodule

// File: rtl/output_matrix_fifo.sv
// Result-matrix output buffer: DEPTH packed matrices in FIFO order with
// first-word fall-through read-out, back-pressure and a sticky overflow flag.
module output_matrix_fifo #(
  parameter  int unsigned ELEM_W = matrix_pkg::ELEM_W,
  parameter  int unsigned ROWS   = matrix_pkg::ROWS,
  parameter  int unsigned COLS   = matrix_pkg::COLS,
  parameter  int unsigned DEPTH  = matrix_pkg::DEPTH,
  localparam int unsigned MAT_W  = ELEM_W * ROWS * COLS,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write_data,
  input  logic [MAT_W-1:0] data_to_write,
  output logic             full,
  output logic [MAT_W-1:0] data,
  output logic             data_valid,
  input  logic             read_ack,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic [MAT_W-1:0] mem [DEPTH];

  fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .write_data (write_data),
    .read_ack   (read_ack),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .push       (push),
    .count      (count),
    .full       (full),
    .data_valid (data_valid),
    .overflow   (overflow)
  );

  // Storage is deliberately not reset; stale entries are hidden by the output mask.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_to_write;
  end

  assign data = data_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_output_matrix_fifo.sv
// Bench for output_matrix_fifo: directed scenarios on a DEPTH=4 build plus
// randomized traffic on DEPTH=4 and DEPTH=3 builds against a queue model.
module tb_output_matrix_fifo;
  import matrix_pkg::*;

  logic             clk;
  logic             reset;
  logic             clr_i [2];
  logic             wr_i  [2];
  logic             ack_i [2];
  logic [MAT_W-1:0] din_i [2];
  logic             full_w [2];
  logic             dv_w   [2];
  logic             ovf_w  [2];
  logic [MAT_W-1:0] data_w [2];
  logic [2:0]       cnt4;
  logic [1:0]       cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [MAT_W-1:0] q0 [$];
  logic [MAT_W-1:0] q1 [$];
  bit               movf [2];
  int               dep  [2] = '{4, 3};

  output_matrix_fifo #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clr_i[0]), .write_data(wr_i[0]),
    .data_to_write(din_i[0]), .full(full_w[0]), .data(data_w[0]),
    .data_valid(dv_w[0]), .read_ack(ack_i[0]), .count(cnt4), .overflow(ovf_w[0])
  );

  output_matrix_fifo #(.DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .clear(clr_i[1]), .write_data(wr_i[1]),
    .data_to_write(din_i[1]), .full(full_w[1]), .data(data_w[1]),
    .data_valid(dv_w[1]), .read_ack(ack_i[1]), .count(cnt3), .overflow(ovf_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MAT_W-1:0] mk(input int unsigned k);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        m[elem_offset(r, c) +: ELEM_W] = {4'h0, 4'(k), 4'(r), 4'(c)};
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] rnd_mat();
    logic [MAT_W-1:0] m;
    for (int unsigned i = 0; i < MAT_W / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic int msize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [MAT_W-1:0] mhead(input int d);
    if (msize(d) == 0) return '0;
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int got_cnt(input int d);
    return (d == 0) ? int'(cnt4) : int'(cnt3);
  endfunction

  task automatic model_step(input int d, input bit clr, input bit wr, input bit ack,
                            input logic [MAT_W-1:0] din);
    int sz;
    bit pop;
    sz = msize(d);
    if (clr) begin
      if (d == 0) q0.delete(); else q1.delete();
      movf[d] = 1'b0;
      return;
    end
    pop = ack && (sz != 0);
    if (pop) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (wr) begin
      if (sz < dep[d] || pop) begin
        if (d == 0) q0.push_back(din); else q1.push_back(din);
      end else movf[d] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs on FIFO d, advance the model, sample at edge+1.
  task automatic cycle(input int d, input bit clr, input bit wr, input bit ack,
                       input logic [MAT_W-1:0] din);
    clr_i[d] = clr; wr_i[d] = wr; ack_i[d] = ack; din_i[d] = din;
    @(posedge clk);
    model_step(d, clr, wr, ack, din);
    #1;
    clr_i[d] = 1'b0; wr_i[d] = 1'b0; ack_i[d] = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (cnt4 !== 3'd0) begin $display("FAIL rst_count actual=%0d expected=0", cnt4); n_bad++; end
    n_cmp++; if (dv_w[0] !== 1'b0 || full_w[0] !== 1'b0) begin
      $display("FAIL rst_flags actual dv=%b full=%b expected dv=0 full=0", dv_w[0], full_w[0]); n_bad++; end
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, mk(k + 1));
    n_cmp++; if (cnt4 !== 3'd3) begin $display("FAIL rst_prefill_count actual=%0d expected=3", cnt4); n_bad++; end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (cnt4 !== 3'd0) begin $display("FAIL rst_async_count actual=%0d expected=0", cnt4); n_bad++; end
    n_cmp++; if (dv_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
      $display("FAIL rst_async_flags actual dv=%b ovf=%b expected 0 0", dv_w[0], ovf_w[0]); n_bad++; end
    n_cmp++; if (data_w[0] !== '0) begin $display("FAIL rst_async_data actual=%h expected=0", data_w[0]); n_bad++; end
    q0.delete(); q1.delete(); movf[0] = 1'b0; movf[1] = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_order();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 0, mk(k));
      n_cmp++; if (cnt4 !== 3'(k + 1)) begin $display("FAIL order_fill_count actual=%0d expected=%0d", cnt4, k + 1); n_bad++; end
      n_cmp++; if (data_w[0] !== mk(0)) begin $display("FAIL order_fwft_head actual=%h expected=%h", data_w[0], mk(0)); n_bad++; end
    end
    n_cmp++; if (full_w[0] !== 1'b1) begin $display("FAIL order_full actual=%b expected=1", full_w[0]); n_bad++; end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (data_w[0] !== mk(k) || dv_w[0] !== 1'b1) begin
        $display("FAIL order_pop_data actual=%h dv=%b expected=%h dv=1", data_w[0], dv_w[0], mk(k)); n_bad++; end
      cycle(0, 0, 0, 1, '0);
    end
    n_cmp++; if (dv_w[0] !== 1'b0 || data_w[0] !== '0 || cnt4 !== 3'd0) begin
      $display("FAIL order_drained actual dv=%b cnt=%0d data=%h expected dv=0 cnt=0 data=0", dv_w[0], cnt4, data_w[0]); n_bad++; end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, mk(k));
    cycle(0, 0, 1, 0, mk(9));
    n_cmp++; if (cnt4 !== 3'd4 || data_w[0] !== mk(0)) begin
      $display("FAIL ovf_dropped actual cnt=%0d head=%h expected cnt=4 head=%h", cnt4, data_w[0], mk(0)); n_bad++; end
    n_cmp++; if (ovf_w[0] !== 1'b1) begin $display("FAIL ovf_set actual=%b expected=1", ovf_w[0]); n_bad++; end
    cycle(0, 0, 0, 1, '0);
    n_cmp++; if (ovf_w[0] !== 1'b1 || data_w[0] !== mk(1) || cnt4 !== 3'd3) begin
      $display("FAIL ovf_sticky actual ovf=%b cnt=%0d head=%h expected ovf=1 cnt=3 head=%h", ovf_w[0], cnt4, data_w[0], mk(1)); n_bad++; end
    cycle(0, 1, 1, 1, mk(10));
    n_cmp++; if (cnt4 !== 3'd0 || ovf_w[0] !== 1'b0 || dv_w[0] !== 1'b0) begin
      $display("FAIL ovf_clear actual cnt=%0d ovf=%b dv=%b expected 0 0 0", cnt4, ovf_w[0], dv_w[0]); n_bad++; end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, mk(k));
    cycle(0, 0, 1, 1, mk(5));
    n_cmp++; if (data_w[0] !== mk(1) || cnt4 !== 3'd4 || ovf_w[0] !== 1'b0) begin
      $display("FAIL simul_full actual head=%h cnt=%0d ovf=%b expected head=%h cnt=4 ovf=0", data_w[0], cnt4, ovf_w[0], mk(1)); n_bad++; end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, '0);
    n_cmp++; if (data_w[0] !== mk(5) || cnt4 !== 3'd1) begin
      $display("FAIL simul_tail actual head=%h cnt=%0d expected head=%h cnt=1", data_w[0], cnt4, mk(5)); n_bad++; end
    cycle(0, 0, 0, 1, '0);
    cycle(0, 0, 1, 1, mk(6));
    n_cmp++; if (cnt4 !== 3'd1 || data_w[0] !== mk(6) || dv_w[0] !== 1'b1) begin
      $display("FAIL simul_empty actual cnt=%0d head=%h dv=%b expected cnt=1 head=%h dv=1", cnt4, data_w[0], dv_w[0], mk(6)); n_bad++; end
    cycle(0, 1, 0, 0, '0);
  endtask

  task automatic test_empty_ack();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1, '0);
      n_cmp++; if (cnt4 !== 3'd0 || dv_w[0] !== 1'b0 || ovf_w[0] !== 1'b0 || data_w[0] !== '0) begin
        $display("FAIL empty_ack actual cnt=%0d dv=%b ovf=%b expected 0 0 0", cnt4, dv_w[0], ovf_w[0]); n_bad++; end
    end
    cycle(0, 0, 1, 0, mk(7));
    n_cmp++; if (cnt4 !== 3'd1 || data_w[0] !== mk(7)) begin
      $display("FAIL empty_ack_push actual cnt=%0d head=%h expected cnt=1 head=%h", cnt4, data_w[0], mk(7)); n_bad++; end
    cycle(0, 0, 0, 1, '0);
  endtask

  // Alternating push/pop pairs walk the pointers round the ring, then mixed random traffic.
  task automatic test_wrap_random();
    logic [MAT_W-1:0] exp_h;
    int               sz;
    bit               c, w, a;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 180; i++) begin
        if (i < 20) begin
          c = 1'b0; w = (i % 2 == 0); a = (i % 2 == 1);
        end else begin
          c = ($urandom_range(0, 19) == 0);
          w = ($urandom_range(0, 9) < 6);
          a = ($urandom_range(0, 1) == 1);
        end
        cycle(d, c, w, a, rnd_mat());
        sz    = msize(d);
        exp_h = mhead(d);
        n_cmp++; if (got_cnt(d) != sz) begin
          $display("FAIL wrap%0d_count cyc=%0d actual=%0d expected=%0d", d, i, got_cnt(d), sz); n_bad++; end
        n_cmp++; if (dv_w[d] !== (sz != 0) || full_w[d] !== (sz == dep[d]) || ovf_w[d] !== movf[d]) begin
          $display("FAIL wrap%0d_flags cyc=%0d actual dv=%b full=%b ovf=%b expected dv=%b full=%b ovf=%b",
                   d, i, dv_w[d], full_w[d], ovf_w[d], sz != 0, sz == dep[d], movf[d]); n_bad++; end
        n_cmp++; if (data_w[d] !== exp_h) begin
          $display("FAIL wrap%0d_data cyc=%0d actual=%h expected=%h", d, i, data_w[d], exp_h); n_bad++; end
        n_cmp++; if (data_w[d][elem_offset(3, 3) +: ELEM_W] !== exp_h[elem_offset(3, 3) +: ELEM_W]) begin
          $display("FAIL wrap%0d_elem33 cyc=%0d actual=%h expected=%h", d, i,
                   data_w[d][elem_offset(3, 3) +: ELEM_W], exp_h[elem_offset(3, 3) +: ELEM_W]); n_bad++; end
      end
      cycle(d, 1, 0, 0, '0);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clr_i[d] = 1'b0; wr_i[d] = 1'b0; ack_i[d] = 1'b0; din_i[d] = '0;
    end
    #12 reset = 1'b1;
    test_reset();
    test_order();
    test_overflow();
    test_simultaneous();
    test_empty_ack();
    test_wrap_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
